fpu_pipe: RTL
=============

Name: fpu_pipe

Overview:
- Pipelined, handshaked successor to the combinational bfloat16 FPU.
- Parametrised floating-point format; two-stage pipeline built around the existing fp_add and fp_mul cores.
- Adds SUB and MAC (multiply-accumulate into an internal accumulator) modes, valid/ready flow control, a tag passthrough, and a sticky overflow flag.
- Sits between the operand scheduler and the result writeback in the datapath.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- FRAC_WIDTH, 7, stored fraction width.
- DW, 1+EXP_WIDTH+FRAC_WIDTH, operand/result width (derived; not overridden).
- TAG_WIDTH, 4, opaque request tag carried alongside each operation.

Ports:
- clk_i  input  1  clock; all state rises on posedge.
- rst_ni  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  request accepted when in_valid_i && in_ready_o.
- mode_i  input  MODE_WIDTH(2)  0=ADD, 1=SUB, 2=MUL, 3=MAC.
- in1_i  input  DW  operand A.
- in2_i  input  DW  operand B.
- tag_i  input  TAG_WIDTH  request tag.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer ready.
- out_o  output  DW  result.
- tag_o  output  TAG_WIDTH  tag of the result.
- ovf_o  output  1  per-result overflow; valid with out_valid_o.
- ovf_sticky_o  output  1  OR of all delivered ovf_o since the last clear.
- acc_o  output  DW  current accumulator value.
- acc_clr_i  input  1  synchronous clear of the accumulator to +0.
- sticky_clr_i  input  1  synchronous clear of ovf_sticky_o.

Behaviour:
- Reset (async, rst_ni=0): both stage valids=0, out_o=0, tag_o=0, ovf_o=0, ovf_sticky_o=0, acc=+0 (all zeros). in_ready_o=1 once out of reset.
- Pipeline:
  - S1 registers mode, tag, in1, in2, and the fp_mul product of in1*in2.
  - S2 registers the result.
  - Latency is exactly 2 cycles from acceptance to out_valid_o when unstalled; throughput is 1 per cycle.
- Advance condition: adv = !out_valid_o || out_ready_i.
  - S2 loads from S1 when adv.
  - S1 loads from input when adv, or when S1 is empty.
  - in_ready_o = adv || !s1_valid.
  - A stall holds all stage contents stable; out_o, tag_o and ovf_o do not change while out_valid_o && !out_ready_i.
- S2 arithmetic (single fp_add instance):
  - ADD: in1+in2.
  - SUB: in1 + (in2 with sign bit inverted).
  - MUL: S1 product passed through.
  - MAC: acc + S1 product. acc updates to that sum at the same edge S2 loads it.
  - Back-to-back MACs therefore see the updated acc with no hazard or stall.
- acc is modified only by a MAC entering S2, or by acc_clr_i.
  - acc_clr_i and a MAC entering S2 in the same cycle: the clear wins (acc=+0). That MAC's out_o still reports the sum using the old acc.
- Overflow: ovf_o=1 when the fp core result exponent is all-ones from finite inputs. The result is then signed infinity (e.g. 0x7F80/0xFF80 for bfloat16).
  - For MAC, overflow also saturates acc to infinity.
  - NaN/inf inputs propagate per core rules, with ovf_o=0.
- ovf_sticky_o sets on an output handshake carrying ovf_o=1.
  - sticky_clr_i clears it.
  - Simultaneous set and clear: set wins.
- Rounding and denormal handling are inherited unchanged from fp_add/fp_mul.
- Reset asserted mid-operation discards in-flight results; no output handshake occurs for them.

Decomposition:
- data_type_pkg gains:
  - an fpu_mode_e enum: MODE_ADD, MODE_SUB, MODE_MUL, MODE_MAC, width MODE_WIDTH=2;
  - a parametrised helper for sign-flip and infinity-pattern construction.
- fp_add and fp_mul are instantiated via op_intf, not duplicated.
- One natural sub-module: fpu_pipe_ctrl. It holds the valid/ready stage control, the adv/in_ready logic and the sticky flag.

Test Plan:
- ADD 0x3F80+0x4000, tag 5, out_ready_i=1 -> out_o=0x4040, tag_o=5 exactly 2 cycles after the accept handshake; ovf_o=0.
- SUB 0x4040-0x3F80 -> 0x4000. Issue 8 back-to-back random ADD/SUB/MUL operations -> one result per cycle, in order, with matching tags.
- acc_clr_i, then MAC(0x4000,0x4040) -> out_o=acc_o=0x40C0. The next-cycle MAC(0x3F80,0x3FC0) -> out_o=acc_o=0x40F0.
- MUL 0x7F7F*0x4000 -> out_o=0x7F80, ovf_o=1, ovf_sticky_o=1 after the handshake. It stays 1 until a sticky_clr_i pulse drops it to 0 the next cycle.
- Hold out_ready_i=0 for 5 cycles with 3 requests offered -> exactly 2 accepted, in_ready_o=0, outputs stable. After release, all 3 results drain in order.
- Assert rst_ni=0 with both stages full -> out_valid_o=0 and acc_o=0 immediately (asynchronously), and no stale result appears after reset release.

Source files
------------

// File: rtl/data_type_pkg.sv
// Shared FPU types and format helpers. Helpers build bit patterns in a wide
// word so any EXP_WIDTH/FRAC_WIDTH combination can share them; callers truncate.
package data_type_pkg;
    localparam int MODE_WIDTH = 2;
    localparam int FP_MAX_W   = 64;

    typedef enum logic [MODE_WIDTH-1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_MUL = 2'd2,
        MODE_MAC = 2'd3
    } fpu_mode_e;

    function automatic logic [FP_MAX_W-1:0] fp_flip_sign(input logic [FP_MAX_W-1:0] x,
                                                         input int dw);
        return x ^ (FP_MAX_W'(1) << (dw - 1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w,
                                                   input int frac_w);
        logic [FP_MAX_W-1:0] exp_ones;
        exp_ones = (FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1);
        return (exp_ones << frac_w) | (FP_MAX_W'(sign) << (exp_w + frac_w));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int frac_w);
        return fp_inf(1'b0, exp_w, frac_w) | (FP_MAX_W'(1) << (frac_w - 1));
    endfunction
endpackage

// File: rtl/op_intf.sv
// Operand/result bundle connecting the pipeline to a combinational fp core.
interface op_intf #(
    parameter int DW = 16
);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] y;
    logic          ovf;

    modport core (input a, input b, output y, output ovf);
    modport user (output a, output b, input y, input ovf);
endinterface

// File: rtl/fp_add.sv
// Combinational floating-point adder: round-to-nearest-even, denormals flushed
// to zero, exact cancellation gives +0, ovf flags an infinite result from finite inputs.
module fp_add
    import data_type_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7
) (
    op_intf.core op
);
    localparam int DW = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int MW = FRAC_WIDTH + 1;
    localparam int XW = MW + 3;
    localparam int EW = EXP_WIDTH + 2;
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

    logic                  sa, sb, sx, sy;
    logic [EXP_WIDTH-1:0]  ea, eb, ex, ey, diff;
    logic [FRAC_WIDTH-1:0] fa, fb, fx, fy, frac;
    logic                  nan_a, nan_b, inf_a, inf_b, swap, found;
    logic [XW-1:0]         mx, my, my_sh, norm;
    logic [XW:0]           sum;
    logic [MW-1:0]         mant;
    logic [MW:0]           mant_r;
    logic                  guard, sticky;
    logic signed [EW-1:0]  exp_s;
    int                    lz;

    always_comb begin
        {sa, ea, fa} = op.a;
        {sb, eb, fb} = op.b;
        nan_a = (ea == EXP_ONES) && (fa != '0);
        nan_b = (eb == EXP_ONES) && (fb != '0);
        inf_a = (ea == EXP_ONES) && (fa == '0);
        inf_b = (eb == EXP_ONES) && (fb == '0);

        // x carries the larger magnitude so the aligned difference never goes negative
        swap         = {eb, fb} > {ea, fa};
        {sx, ex, fx} = swap ? op.b : op.a;
        {sy, ey, fy} = swap ? op.a : op.b;
        mx   = (ex == '0) ? '0 : {1'b1, fx, 3'b000};
        my   = (ey == '0) ? '0 : {1'b1, fy, 3'b000};
        diff = ex - ey;
        if (int'(diff) >= XW) begin
            my_sh = {{(XW-1){1'b0}}, |my};
        end else begin
            my_sh    = my >> diff;
            my_sh[0] = my_sh[0] | (|(my & ~({XW{1'b1}} << diff)));
        end
        sum = (sx == sy) ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});

        exp_s = EW'(ex);
        lz    = 0;
        found = 1'b0;
        if (sum[XW]) begin
            norm  = {sum[XW:2], sum[1] | sum[0]};
            exp_s = exp_s + EW'(1);
        end else begin
            for (int i = XW - 1; i >= 0; i--) begin
                if (!found && sum[i]) begin
                    found = 1'b1;
                    lz    = XW - 1 - i;
                end
            end
            norm  = sum[XW-1:0] << lz;
            exp_s = exp_s - EW'(lz);
        end

        mant   = norm[XW-1:3];
        guard  = norm[2];
        sticky = |norm[1:0];
        mant_r = {1'b0, mant} + {{MW{1'b0}}, guard & (sticky | mant[0])};
        frac   = mant_r[MW] ? mant_r[MW-1:1] : mant_r[MW-2:0];
        exp_s  = exp_s + EW'(mant_r[MW]);

        op.ovf = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            op.y = DW'(fp_qnan(EXP_WIDTH, FRAC_WIDTH));
        end else if (inf_a) begin
            op.y = DW'(fp_inf(sa, EXP_WIDTH, FRAC_WIDTH));
        end else if (inf_b) begin
            op.y = DW'(fp_inf(sb, EXP_WIDTH, FRAC_WIDTH));
        end else if (sum == '0) begin
            op.y = {sa & sb, {(DW-1){1'b0}}};
        end else if (exp_s >= $signed({2'b00, EXP_ONES})) begin
            op.y   = DW'(fp_inf(sx, EXP_WIDTH, FRAC_WIDTH));
            op.ovf = 1'b1;
        end else if (exp_s <= 0) begin
            op.y = {sx, {(DW-1){1'b0}}};
        end else begin
            op.y = {sx, exp_s[EXP_WIDTH-1:0], frac};
        end
    end
endmodule

// File: rtl/fp_mul.sv
// Combinational floating-point multiplier: round-to-nearest-even, denormals
// flushed to zero, ovf flags an infinite result produced from finite operands.
module fp_mul
    import data_type_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7
) (
    op_intf.core op
);
    localparam int DW   = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int MW   = FRAC_WIDTH + 1;
    localparam int PW   = 2 * MW;
    localparam int EW   = EXP_WIDTH + 2;
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

    logic                  sa, sb, sy;
    logic [EXP_WIDTH-1:0]  ea, eb;
    logic [FRAC_WIDTH-1:0] fa, fb, frac;
    logic                  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [PW-1:0]         prod, norm;
    logic [MW-1:0]         mant;
    logic [MW:0]           mant_r;
    logic                  guard, sticky;
    logic signed [EW-1:0]  exp_s;

    always_comb begin
        {sa, ea, fa} = op.a;
        {sb, eb, fb} = op.b;
        sy     = sa ^ sb;
        nan_a  = (ea == EXP_ONES) && (fa != '0);
        nan_b  = (eb == EXP_ONES) && (fb != '0);
        inf_a  = (ea == EXP_ONES) && (fa == '0);
        inf_b  = (eb == EXP_ONES) && (fb == '0);
        zero_a = (ea == '0);
        zero_b = (eb == '0);

        prod   = PW'({1'b1, fa}) * PW'({1'b1, fb});
        norm   = prod[PW-1] ? prod : (prod << 1);
        mant   = norm[PW-1 -: MW];
        guard  = norm[PW-MW-1];
        sticky = |norm[PW-MW-2:0];
        mant_r = {1'b0, mant} + {{MW{1'b0}}, guard & (sticky | mant[0])};
        frac   = mant_r[MW] ? mant_r[MW-1:1] : mant_r[MW-2:0];
        exp_s  = EW'(ea) + EW'(eb) - EW'(BIAS) + EW'(prod[PW-1]) + EW'(mant_r[MW]);

        op.ovf = 1'b0;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            op.y = DW'(fp_qnan(EXP_WIDTH, FRAC_WIDTH));
        end else if (inf_a || inf_b) begin
            op.y = DW'(fp_inf(sy, EXP_WIDTH, FRAC_WIDTH));
        end else if (zero_a || zero_b) begin
            op.y = {sy, {(DW-1){1'b0}}};
        end else if (exp_s >= $signed({2'b00, EXP_ONES})) begin
            op.y   = DW'(fp_inf(sy, EXP_WIDTH, FRAC_WIDTH));
            op.ovf = 1'b1;
        end else if (exp_s <= 0) begin
            op.y = {sy, {(DW-1){1'b0}}};
        end else begin
            op.y = {sy, exp_s[EXP_WIDTH-1:0], frac};
        end
    end
endmodule

// File: rtl/fpu_pipe_ctrl.sv
// Two-stage valid/ready control and the sticky overflow flag for fpu_pipe.
module fpu_pipe_ctrl (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    input  logic out_ready_i,
    input  logic ovf_i,
    input  logic sticky_clr_i,
    output logic in_ready_o,
    output logic s1_en_o,
    output logic s2_en_o,
    output logic out_valid_o,
    output logic ovf_sticky_o
);
    // Handshake: a transfer happens on a posedge where valid && ready; a
    // producer holds valid and payload stable until that edge, and the output
    // stage holds its payload while out_valid_o && !out_ready_i.
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic sticky_q, sticky_d;
    logic adv;

    always_comb begin
        adv        = !s2_valid_q || out_ready_i;
        in_ready_o = adv || !s1_valid_q;
        s1_en_o    = in_valid_i && in_ready_o;
        s2_en_o    = adv && s1_valid_q;
        s1_valid_d = in_ready_o ? in_valid_i : s1_valid_q;
        s2_valid_d = adv ? s1_valid_q : s2_valid_q;
        // set wins over a simultaneous clear
        sticky_d   = (sticky_q && !sticky_clr_i) || (s2_valid_q && out_ready_i && ovf_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sticky_q   <= sticky_d;
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign ovf_sticky_o = sticky_q;
endmodule

// File: rtl/fpu_pipe.sv
// Two-stage handshaked FPU: S1 captures operands and the product, S2 runs the
// shared adder for ADD/SUB/MAC and owns the accumulator.
module fpu_pipe
    import data_type_pkg::*;
#(
    parameter  int EXP_WIDTH  = 8,
    parameter  int FRAC_WIDTH = 7,
    parameter  int TAG_WIDTH  = 4,
    localparam int DW         = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [MODE_WIDTH-1:0] mode_i,
    input  logic [DW-1:0]         in1_i,
    input  logic [DW-1:0]         in2_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DW-1:0]         out_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  ovf_o,
    output logic                  ovf_sticky_o,
    output logic [DW-1:0]         acc_o,
    input  logic                  acc_clr_i,
    input  logic                  sticky_clr_i
);
    logic s1_en, s2_en;

    fpu_mode_e            s1_mode_q, s1_mode_d;
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d, out_tag_q, out_tag_d;
    logic [DW-1:0]        s1_in1_q, s1_in1_d, s1_in2_q, s1_in2_d;
    logic [DW-1:0]        s1_prod_q, s1_prod_d, out_q, out_d, acc_q, acc_d;
    logic                 s1_prod_ovf_q, s1_prod_ovf_d, out_ovf_q, out_ovf_d;
    logic [DW-1:0]        res;
    logic                 res_ovf;

    op_intf #(.DW(DW)) mul_if ();
    op_intf #(.DW(DW)) add_if ();

    fp_mul #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_mul (.op(mul_if));
    fp_add #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_add (.op(add_if));

    fpu_pipe_ctrl u_ctrl (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .out_ready_i  (out_ready_i),
        .ovf_i        (out_ovf_q),
        .sticky_clr_i (sticky_clr_i),
        .in_ready_o   (in_ready_o),
        .s1_en_o      (s1_en),
        .s2_en_o      (s2_en),
        .out_valid_o  (out_valid_o),
        .ovf_sticky_o (ovf_sticky_o)
    );

    assign mul_if.a = in1_i;
    assign mul_if.b = in2_i;

    always_comb begin
        s1_mode_d     = s1_en ? fpu_mode_e'(mode_i) : s1_mode_q;
        s1_tag_d      = s1_en ? tag_i : s1_tag_q;
        s1_in1_d      = s1_en ? in1_i : s1_in1_q;
        s1_in2_d      = s1_en ? in2_i : s1_in2_q;
        s1_prod_d     = s1_en ? mul_if.y : s1_prod_q;
        s1_prod_ovf_d = s1_en ? mul_if.ovf : s1_prod_ovf_q;
    end

    always_comb begin
        add_if.a = (s1_mode_q == MODE_MAC) ? acc_q : s1_in1_q;
        case (s1_mode_q)
            MODE_SUB: add_if.b = DW'(fp_flip_sign(FP_MAX_W'(s1_in2_q), DW));
            MODE_MAC: add_if.b = s1_prod_q;
            default:  add_if.b = s1_in2_q;
        endcase

        // a product that already overflowed still counts as overflow after the MAC add
        case (s1_mode_q)
            MODE_MUL: begin
                res     = s1_prod_q;
                res_ovf = s1_prod_ovf_q;
            end
            MODE_MAC: begin
                res     = add_if.y;
                res_ovf = s1_prod_ovf_q | add_if.ovf;
            end
            default: begin
                res     = add_if.y;
                res_ovf = add_if.ovf;
            end
        endcase

        out_d     = s2_en ? res : out_q;
        out_tag_d = s2_en ? s1_tag_q : out_tag_q;
        out_ovf_d = s2_en ? res_ovf : out_ovf_q;

        acc_d = acc_q;
        if (s2_en && (s1_mode_q == MODE_MAC)) begin
            acc_d = res;
        end
        if (acc_clr_i) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_mode_q     <= MODE_ADD;
            s1_tag_q      <= '0;
            s1_in1_q      <= '0;
            s1_in2_q      <= '0;
            s1_prod_q     <= '0;
            s1_prod_ovf_q <= 1'b0;
            out_q         <= '0;
            out_tag_q     <= '0;
            out_ovf_q     <= 1'b0;
            acc_q         <= '0;
        end else begin
            s1_mode_q     <= s1_mode_d;
            s1_tag_q      <= s1_tag_d;
            s1_in1_q      <= s1_in1_d;
            s1_in2_q      <= s1_in2_d;
            s1_prod_q     <= s1_prod_d;
            s1_prod_ovf_q <= s1_prod_ovf_d;
            out_q         <= out_d;
            out_tag_q     <= out_tag_d;
            out_ovf_q     <= out_ovf_d;
            acc_q         <= acc_d;
        end
    end

    assign out_o = out_q;
    assign tag_o = out_tag_q;
    assign ovf_o = out_ovf_q;
    assign acc_o = acc_q;
endmodule
